// File: rtl/risc_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_mem_pkg
// Description : Shared types and constants for the unified memory port:
//               arbiter state encoding, requester IDs, byte-enable patterns.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

endpackage : risc_mem_pkg
`default_nettype wire

// File: rtl/mem_byte_lane.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_lane
// Description : Combinational lane handling for the memory port: byte-enable
//               generation, byte-store replication and load extraction with
//               sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_byte_lane
  import risc_mem_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              is_byte_i,
  input  logic              we_i,
  input  logic              sign_i,
  input  logic              lane_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [1:0]        be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [7:0] byte_sel;

  // Steer write lanes, pick byte enables and shape the returned read word
  always_comb begin
    be_o        = BE_WORD;
    mem_wdata_o = wdata_i;
    rdata_o     = '0;
    byte_sel    = lane_i ? mem_rdata_i[15:8] : mem_rdata_i[7:0];
    if (is_byte_i) begin
      be_o        = lane_i ? BE_HI : BE_LO;
      // Replicating the byte means the memory needs no lane shifter of its own
      mem_wdata_o = {wdata_i[7:0], wdata_i[7:0]};
    end
    // Stores return zero; loads return the whole word or the extended byte
    if (!we_i) begin
      if (is_byte_i) begin
        rdata_o = {{8{sign_i & byte_sel[7]}}, byte_sel};
      end else begin
        rdata_o = mem_rdata_i;
      end
    end
  end

endmodule : mem_byte_lane
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing one memory port between the
//               instruction fetch and load/store requesters, with registered
//               response and optional access timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import risc_mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic              d_sign,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 2);

  arb_state_t        state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic              gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              byte_q, byte_d;
  logic              sign_q, sign_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              w_gnt;
  logic              w_timeout;
  logic [1:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;

  // A lone request wins outright; a tie goes to whoever was not served last
  assign w_gnt = (if_req && d_req) ? ~rr_last_q : d_req;

  assign w_timeout = (TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  mem_byte_lane #(
    .DATA_W (DATA_W)
  ) u_lane (
    .is_byte_i   (byte_q),
    .we_i        (we_q),
    .sign_i      (sign_q),
    .lane_i      (addr_q[0]),
    .wdata_i     (wdata_q),
    .mem_rdata_i (mem_rdata),
    .be_o        (w_be),
    .mem_wdata_o (w_wdata),
    .rdata_o     (w_rdata)
  );

  // State and latched-request registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_last_q <= REQ_D;
      gnt_q     <= REQ_IF;
      addr_q    <= '0;
      we_q      <= 1'b0;
      byte_q    <= 1'b0;
      sign_q    <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      byte_q    <= byte_d;
      sign_q    <= sign_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: grant and latch in IDLE, wait/timeout in ISSUE, ack in RESP
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    byte_d    = byte_q;
    sign_d    = sign_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          gnt_d     = w_gnt;
          rr_last_d = w_gnt;
          cnt_d     = '0;
          err_d     = 1'b0;
          state_d   = ST_ISSUE;
          if (w_gnt == REQ_D) begin
            addr_d  = d_addr;
            we_d    = d_we;
            byte_d  = d_byte;
            sign_d  = d_sign;
            wdata_d = d_wdata;
          end else begin
            // Fetch is always a word read
            addr_d  = if_addr;
            we_d    = 1'b0;
            byte_d  = 1'b0;
            sign_d  = 1'b0;
            wdata_d = '0;
          end
        end
      end
      ST_ISSUE: begin
        if (mem_ready) begin
          rdata_d = w_rdata;
          state_d = ST_RESP;
        end else if (w_timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Memory strobes are only live in ISSUE so IDLE/RESP present a quiet bus
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 2'b00;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ST_ISSUE) begin
      mem_en    = 1'b1;
      mem_we    = we_q;
      mem_be    = w_be;
      mem_addr  = {addr_q[ADDR_W-1:1], 1'b0};
      mem_wdata = w_wdata;
    end
  end

  assign if_ack = (state_q == ST_RESP) && (gnt_q == REQ_IF);
  assign d_ack  = (state_q == ST_RESP) && (gnt_q == REQ_D);
  assign err    = (state_q == ST_RESP) && err_q;
  assign rdata  = rdata_q;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter: directed cases for
//               latency, lanes, arbitration, timeout and reset, followed by
//               randomized accesses checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic        d_req, d_we, d_byte, d_sign;
  logic [15:0] d_addr, d_wdata;
  logic        d_ack;
  logic [15:0] rdata;
  logic        err, mem_en, mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  int n_cmp = 0;
  int n_err = 0;
  bit rr_model;  // requester served most recently: 0 = fetch, 1 = data

  mem_port_arbiter #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_byte    (d_byte),
    .d_sign    (d_sign),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .rdata     (rdata),
    .err       (err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value the requester should see on rdata, derived from the access rules
  function automatic logic [15:0] model_rdata(input bit to, input bit we, input bit bt,
                                              input bit sign, input bit a0,
                                              input logic [15:0] m);
    logic [15:0] b;
    if (to || we) return 16'h0000;
    if (!bt) return m;
    b = a0 ? (m >> 8) : (m & 16'h00FF);
    if (sign && b >= 16'd128) b = b + 16'hFF00;
    return b;
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, "_mem_en"}, {15'd0, mem_en}, 16'd0);
    chk({tag, "_acks"}, {13'd0, if_ack, d_ack, err}, 16'd0);
    chk({tag, "_mem_be"}, {14'd0, mem_be}, 16'd0);
    chk({tag, "_mem_addr"}, mem_addr, 16'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 16'd0);
  endtask

  // One access from a single requester; called #1 after a rising edge in IDLE.
  // waits = number of ISSUE cycles with mem_ready low before it is raised.
  task automatic single(input bit is_d, input logic [15:0] addr, input bit we,
                        input bit bt, input bit sign, input logic [15:0] wdata,
                        input logic [15:0] mrd, input int waits);
    bit          to;
    int          n;
    logic [15:0] ea, ew, er;
    logic [1:0]  eb;
    to = (waits >= TIMEOUT);
    n  = to ? TIMEOUT : waits + 1;
    ea = addr & 16'hFFFE;
    eb = (!is_d || !bt) ? 2'b11 : (addr[0] ? 2'b10 : 2'b01);
    ew = bt ? {wdata[7:0], wdata[7:0]} : wdata;
    er = model_rdata(to, is_d && we, is_d && bt, sign, addr[0], mrd);
    rr_model = is_d;
    if (is_d) begin
      d_req = 1'b1; d_addr = addr; d_we = we; d_byte = bt; d_sign = sign; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      chk("issue_mem_en", {15'd0, mem_en}, 16'd1);
      chk("issue_mem_addr", mem_addr, ea);
      chk("issue_mem_be", {14'd0, mem_be}, {14'd0, eb});
      chk("issue_mem_we", {15'd0, mem_we}, {15'd0, is_d && we});
      if (is_d && we) chk("issue_mem_wdata", mem_wdata, ew);
      chk("issue_no_ack", {14'd0, if_ack, d_ack}, 16'd0);
      mem_ready = (k == waits);
      mem_rdata = mrd;
      // Scramble the requester's fields: the latched copy must be used
      d_addr = $urandom; d_wdata = $urandom; if_addr = $urandom;
      d_byte = $urandom; d_sign = $urandom; d_we = $urandom;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    chk("resp_if_ack", {15'd0, if_ack}, {15'd0, !is_d});
    chk("resp_d_ack", {15'd0, d_ack}, {15'd0, is_d});
    chk("resp_err", {15'd0, err}, {15'd0, to});
    chk("resp_rdata", rdata, er);
    chk("resp_mem_en", {15'd0, mem_en}, 16'd0);
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    chk("after_acks", {13'd0, if_ack, d_ack, err}, 16'd0);
  endtask

  // One zero-wait arbitration round with word loads; unserved requests stay held
  task automatic arb(input bit want_if, input bit want_d);
    bit          gnt;
    logic [15:0] m;
    if (want_if) begin if_req = 1'b1; if_addr = $urandom; end
    if (want_d && !d_req) begin
      d_req = 1'b1; d_addr = $urandom; d_we = 1'b0; d_byte = 1'b0; d_sign = 1'b0;
    end
    if (!if_req && !d_req) begin if_req = 1'b1; if_addr = $urandom; end
    gnt = (if_req && d_req) ? !rr_model : d_req;
    rr_model = gnt;
    m = $urandom;
    @(posedge clk); #1;
    chk("arb_mem_en", {15'd0, mem_en}, 16'd1);
    chk("arb_mem_addr", mem_addr, (gnt ? d_addr : if_addr) & 16'hFFFE);
    mem_ready = 1'b1; mem_rdata = m;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("arb_if_ack", {15'd0, if_ack}, {15'd0, !gnt});
    chk("arb_d_ack", {15'd0, d_ack}, {15'd0, gnt});
    chk("arb_rdata", rdata, m);
    if (gnt) d_req = 1'b0; else if_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_byte = 1'b0; d_sign = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    rr_model = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check_quiet("reset");
    chk("reset_rdata", rdata, 16'd0);
    reset = 1'b0;

    // Both requesting out of reset: fetch first, then strict alternation
    for (int i = 0; i < 4; i++) arb(1'b1, 1'b1);
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;

    // Zero-wait fetch
    single(1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 0);
    // Byte loads with sign/zero extension on each lane
    single(1'b1, 16'h0021, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h80F5, 0);
    single(1'b1, 16'h0020, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h80F5, 0);
    single(1'b1, 16'h0021, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h80F5, 0);
    single(1'b1, 16'h0020, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h807F, 0);
    // Byte store to the high lane and word store with odd address
    single(1'b1, 16'h0041, 1'b1, 1'b1, 1'b0, 16'h00AB, 16'h5555, 0);
    single(1'b1, 16'h0043, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h5555, 0);
    // Wait states, last-cycle ready, and timeout
    single(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hCAFE, 3);
    single(1'b0, 16'h0200, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h7777, TIMEOUT - 1);
    single(1'b1, 16'h0300, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h9999, 40);

    // Reset asserted mid-ISSUE: bus drops at once, no ack, request re-granted
    d_req = 1'b1; d_addr = 16'h0501; d_we = 1'b1; d_byte = 1'b1; d_sign = 1'b0; d_wdata = 16'h0033;
    @(posedge clk); #1;
    chk("pre_reset_mem_en", {15'd0, mem_en}, 16'd1);
    #2 reset = 1'b1;
    #1;
    check_quiet("midreset");
    chk("midreset_rdata", rdata, 16'd0);
    @(posedge clk); #1;
    chk("midreset_hold_acks", {14'd0, if_ack, d_ack}, 16'd0);
    reset = 1'b0;
    rr_model = 1'b1;
    single(1'b1, 16'h0501, 1'b1, 1'b1, 1'b0, 16'h0033, 16'h0000, 0);

    // Randomized single-requester accesses
    for (int i = 0; i < 30; i++) begin
      int w;
      w = ($urandom_range(0, 9) == 0) ? TIMEOUT + 2 : $urandom_range(0, 3);
      single(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             16'($urandom), 16'($urandom), w);
    end

    // Randomized contention
    for (int i = 0; i < 20; i++) arb(1'($urandom), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
